// File: rtl/jcr_pkg.sv
// rtl/jcr_pkg.sv - shared MMIO offsets, CMD/STATUS bit positions and FSM encoding for jcr_wb_master
package jcr_pkg;

  // MMIO offsets from the window base
  localparam logic [2:0] OFF_ADDR   = 3'd0;
  localparam logic [2:0] OFF_WDATA  = 3'd1;
  localparam logic [2:0] OFF_CMD    = 3'd2;
  localparam logic [2:0] OFF_STATUS = 3'd3;
  localparam logic [2:0] OFF_RDATA0 = 3'd4;
  localparam logic [2:0] OFF_RDATA1 = 3'd5;
  localparam logic [2:0] OFF_RDATA2 = 3'd6;
  localparam logic [2:0] OFF_RDATA3 = 3'd7;

  // CMD register bit positions
  localparam int CMD_START   = 0;
  localparam int CMD_WE      = 1;
  localparam int CMD_SEL_LSB = 2;
  localparam int CMD_SEL_MSB = 5;

  // STATUS register bit positions
  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_BUS_ERR = 2;
  localparam int STAT_TIMEOUT = 3;

  // Transaction FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } wbm_state_e;

  // Pack the STATUS byte from its flags
  function automatic logic [7:0] pack_status(input logic busy, input logic done,
                                             input logic bus_err, input logic timeout);
    logic [7:0] s;
    s = 8'h00;
    s[STAT_BUSY]    = busy;
    s[STAT_DONE]    = done;
    s[STAT_BUS_ERR] = bus_err;
    s[STAT_TIMEOUT] = timeout;
    return s;
  endfunction

endpackage

// File: rtl/jcr_wb_master.sv
// rtl/jcr_wb_master.sv - CPU MMIO to classic Wishbone single-transfer initiator; optional bus timeout via JCR_WBM_TIMEOUT_EN
module jcr_wb_master
  import jcr_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR      = 8'd240,
  parameter logic [7:0] TIMEOUT_CYCLES = 8'd200
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [7:0]  cpu_addr,
  input  logic [7:0]  cpu_w_data,
  input  logic        cpu_w_en,
  output logic [7:0]  cpu_r_data,
  output logic        cpu_hit,
  output logic        int_req,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i
);

  wbm_state_e  state_q;
  logic        cyc_q;
  logic        we_q;
  logic [3:0]  sel_q;
  logic [31:0] adr_q;
  logic [31:0] wdat_q;
  logic [31:0] rdata_q;
  logic        done_q;
  logic        bus_err_q;
  logic        int_q;
  logic        tmo_flag;

  logic [7:0]  off;
  logic        busy;
  logic        wr_addr;
  logic        wr_wdata;
  logic        wr_cmd;
  logic        wr_status;

`ifdef JCR_WBM_TIMEOUT_EN
  logic        timeout_q;
  logic [7:0]  tmo_cnt_q;
  assign tmo_flag = timeout_q;
`else
  // No timeout hardware: the flag is a constant zero regardless of TIMEOUT_CYCLES
  assign tmo_flag = 1'b0 & (|TIMEOUT_CYCLES);
`endif

  assign off       = cpu_addr - BASE_ADDR;
  assign cpu_hit   = (cpu_addr >= BASE_ADDR) && (off[7:3] == 5'd0);
  assign busy      = (state_q != ST_IDLE);

  assign wr_addr   = cpu_w_en && cpu_hit && (off[2:0] == OFF_ADDR);
  assign wr_wdata  = cpu_w_en && cpu_hit && (off[2:0] == OFF_WDATA);
  assign wr_cmd    = cpu_w_en && cpu_hit && (off[2:0] == OFF_CMD);
  assign wr_status = cpu_w_en && cpu_hit && (off[2:0] == OFF_STATUS);

  // Classic single transfer: strobe is the cycle signal
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = wdat_q;
  assign int_req   = int_q;

  // Combinational readback; write-only offsets and misses read as zero
  always_comb begin
    cpu_r_data = 8'h00;
    if (cpu_hit) begin
      case (off[2:0])
        OFF_STATUS: cpu_r_data = pack_status(busy, done_q, bus_err_q, tmo_flag);
        OFF_RDATA0: cpu_r_data = rdata_q[7:0];
        OFF_RDATA1: cpu_r_data = rdata_q[15:8];
        OFF_RDATA2: cpu_r_data = rdata_q[23:16];
        OFF_RDATA3: cpu_r_data = rdata_q[31:24];
        default:    cpu_r_data = 8'h00;
      endcase
    end
  end

  // MMIO register writes and the IDLE/BUS/DONE transaction FSM
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state_q   <= ST_IDLE;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      sel_q     <= 4'h0;
      adr_q     <= 32'h0;
      wdat_q    <= 32'h0;
      rdata_q   <= 32'h0;
      done_q    <= 1'b0;
      bus_err_q <= 1'b0;
      int_q     <= 1'b0;
`ifdef JCR_WBM_TIMEOUT_EN
      timeout_q <= 1'b0;
      tmo_cnt_q <= 8'h0;
`endif
    end else begin
      // STATUS write clears sticky flags; a completion at the same edge overrides below
      if (wr_status) begin
        done_q    <= 1'b0;
        bus_err_q <= 1'b0;
`ifdef JCR_WBM_TIMEOUT_EN
        timeout_q <= 1'b0;
`endif
      end

      case (state_q)
        ST_IDLE: begin
          if (wr_addr) adr_q <= {adr_q[23:0], cpu_w_data};
          if (wr_wdata) wdat_q <= {wdat_q[23:0], cpu_w_data};
          if (wr_cmd) begin
            we_q  <= cpu_w_data[CMD_WE];
            sel_q <= cpu_w_data[CMD_SEL_MSB:CMD_SEL_LSB];
            if (cpu_w_data[CMD_START]) begin
              state_q   <= ST_BUS;
              cyc_q     <= 1'b1;
              done_q    <= 1'b0;
              bus_err_q <= 1'b0;
`ifdef JCR_WBM_TIMEOUT_EN
              timeout_q <= 1'b0;
              tmo_cnt_q <= 8'h0;
`endif
            end
          end
        end

        ST_BUS: begin
          if (wbm_err_i) begin
            // Error wins over a simultaneous ack; read data is left untouched
            state_q   <= ST_DONE;
            cyc_q     <= 1'b0;
            done_q    <= 1'b1;
            bus_err_q <= 1'b1;
            int_q     <= 1'b1;
          end else if (wbm_ack_i) begin
            state_q <= ST_DONE;
            cyc_q   <= 1'b0;
            done_q  <= 1'b1;
            int_q   <= 1'b1;
            if (!we_q) rdata_q <= wbm_dat_i;
          end
`ifdef JCR_WBM_TIMEOUT_EN
          else if (tmo_cnt_q == TIMEOUT_CYCLES - 8'd1) begin
            state_q   <= ST_DONE;
            cyc_q     <= 1'b0;
            done_q    <= 1'b1;
            bus_err_q <= 1'b1;
            timeout_q <= 1'b1;
            int_q     <= 1'b1;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
          end
`endif
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
          int_q   <= 1'b0;
        end

        default: begin
          state_q <= ST_IDLE;
          cyc_q   <= 1'b0;
          int_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/jcr_wb_master.md
JCR_WB_MASTER -- requirements
Module: jcr_wb_master

Interface
REQ-001 SHALL have parameters: BASE_ADDR, default 8'd240, base of the 8-byte MMIO window in CPU data space; TIMEOUT_CYCLES, default 8'd200, bus-wait limit.
REQ-002 SHALL have one clock and a synchronous, active-low reset: wb_clk_i  in  1  clock; wb_rst_i  in  1  synchronous reset, active-low.
REQ-003 SHALL have CPU-side ports: cpu_addr  in  8  (CPU rs_data); cpu_w_data  in  8  (CPU rd_data); cpu_w_en  in  1  (CPU mem_w_en); cpu_r_data  out  8  readback; cpu_hit  out  1  cpu_addr inside window; int_req  out  1  completion pulse.
REQ-004 SHALL have Wishbone-initiator ports: wbm_cyc_o  out  1; wbm_stb_o  out  1; wbm_we_o  out  1; wbm_sel_o  out  4; wbm_adr_o  out  32; wbm_dat_o  out  32; wbm_dat_i  in  32; wbm_ack_i  in  1; wbm_err_i  in  1.

Function
REQ-005 SHALL decode offsets from BASE_ADDR as follows: +0 ADDR (write, shift: adr <= {adr[23:0],byte}); +1 WDATA (write, same shift); +2 CMD (write: bit0 start, bit1 we, bits5:2 sel); +3 STATUS (read: bit0 busy, bit1 done, bit2 bus_err, bit3 timeout; any write clears bits1-3); +4..+7 RDATA bytes 0..3 (read, byte0 = bits7:0).
REQ-006 SHALL drive cpu_r_data and cpu_hit combinationally from cpu_addr; cpu_r_data SHALL be 0 outside the window or at write-only offsets.
REQ-007 SHALL implement FSM states IDLE, BUS, DONE.
REQ-008 IDLE -> BUS: on a CMD write with start=1 at edge N; cyc/stb/we/sel asserted from cycle N+1; done/bus_err/timeout cleared at edge N.
REQ-009 BUS -> DONE: at the first edge sampling ack or err high; at that edge, when we=0 and ack=1, RDATA SHALL capture wbm_dat_i.
REQ-010 DONE -> IDLE: unconditionally after one cycle; cyc/stb SHALL be low in DONE; int_req SHALL be high exactly during DONE.
REQ-011 Minimum transaction SHALL be cyc high for 1 cycle (ack in first BUS cycle); CMD-write-to-done latency SHALL be 2 edges.
REQ-012 When ack and err are sampled together, err SHALL win: bus_err=1 and RDATA unchanged.
REQ-013 While busy (BUS or DONE), writes to ADDR, WDATA and CMD SHALL be ignored; wbm_adr_o, wbm_dat_o, wbm_sel_o and wbm_we_o SHALL stay stable for the whole cycle.
REQ-014 wbm_cyc_o SHALL equal wbm_stb_o (classic single transfer, no bursts).
REQ-015 ADDR/WDATA shifts SHALL wrap naturally: the oldest byte is discarded after 4 writes.

Reset
REQ-016 Reset SHALL force IDLE; outputs cyc, stb, we, int_req = 0; sel = 0; adr, dat_o, RDATA = 0; STATUS = 0.
REQ-017 Reset asserted during BUS SHALL drop cyc/stb at that same edge with no completion, no int_req, and STATUS = 0.

Configuration
REQ-018 Macro JCR_WBM_TIMEOUT_EN defined: an 8-bit counter SHALL count BUS cycles; when it reaches TIMEOUT_CYCLES with no ack/err, the block SHALL go to DONE with timeout=1 and bus_err=1.
REQ-019 Macro JCR_WBM_TIMEOUT_EN absent: the counter logic SHALL not be present; BUS SHALL wait indefinitely; STATUS bit3 SHALL read 0.

Structure
REQ-020 Shared package jcr_pkg SHALL hold the MMIO offset constants, CMD/STATUS bit positions and the FSM state encoding.
REQ-021 Everything SHALL be a single module with no sub-module; the MMIO decode lives inline with the FSM.

Verification
REQ-022 Write: ADDR bytes 30,00,00,00, WDATA DE,AD,BE,EF, CMD 0x3F -> adr_o=30000000, dat_o=DEADBEEF, we=1, sel=F; slave acks in cycle 2 -> done=1, one int_req pulse.
REQ-023 Read: CMD 0x3D, slave returns 12345678 with ack -> offsets +4..+7 read 78,56,34,12; STATUS=0x02.
REQ-024 Err: slave asserts ack and err together -> STATUS=0x06, RDATA unchanged.
REQ-025 Timeout (macro on, TIMEOUT_CYCLES=8), silent slave -> cyc high exactly 8 cycles, STATUS=0x0E; macro off -> cyc still high after 1000 cycles.
REQ-026 While busy, write ADDR 0xFF and CMD 0x01 -> adr_o unchanged, no second cycle; then reset mid-BUS -> cyc=0 at the reset edge, STATUS=0, no int_req.
